// File: rtl/dmem_store_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_store_buffer
//  Purpose  : M-stage data memory with an in-order posted store buffer (SB).
//             Stores are queued in the SB and drained one at a time into a
//             word array, each head entry holding the array write port for
//             DRAIN_LAT cycles before it commits. Loads read the array, or
//             with forwarding enabled, the youngest matching SB entry.
//  Ports    : clk, reset (sync, active-high)
//             MemWriteM/MemtoRegM  - store / load in M stage
//             ALUOutM              - byte address (word index = [AW+1:2])
//             WriteDataM           - store data
//             DmmRD                - load data (combinational)
//             StallSB              - hold request to the hazard unit
//             SbCount/SbEmpty      - occupancy (registered)
//             SbOverflow           - sticky: a store was dropped
//  Config   : define DMEM_SB_FORWARD_EN to enable SB-to-load forwarding;
//             without it a load that matches a pending entry stalls instead.
//  Revision : 1.0  initial release
// ============================================================================
module dmem_store_buffer #(
    parameter int MEM_WORDS = 256,
    parameter int SB_DEPTH  = 4,
    parameter int DRAIN_LAT = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          MemWriteM,
    input  logic                          MemtoRegM,
    input  logic [31:0]                   ALUOutM,
    input  logic [31:0]                   WriteDataM,
    output logic [31:0]                   DmmRD,
    output logic                          StallSB,
    output logic [$clog2(SB_DEPTH+1)-1:0] SbCount,
    output logic                          SbEmpty,
    output logic                          SbOverflow
);

    localparam int c_AW = $clog2(MEM_WORDS);
    localparam int c_PW = $clog2(SB_DEPTH);
    localparam int c_CW = $clog2(SB_DEPTH + 1);
    localparam int c_DW = (DRAIN_LAT > 1) ? $clog2(DRAIN_LAT) : 1;

    logic [31:0]      r_mem    [MEM_WORDS];
    logic [c_AW-1:0]  r_sbIdx  [SB_DEPTH];
    logic [31:0]      r_sbData [SB_DEPTH];

    logic [c_PW-1:0]  r_head;
    logic [c_PW-1:0]  r_tail;
    logic [c_CW-1:0]  r_count;
    logic [c_DW-1:0]  r_drainCnt;
    logic             r_overflow;

    logic [c_AW-1:0]  w_idx;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic             w_hit;
`ifdef DMEM_SB_FORWARD_EN
    logic [31:0]      w_fwdData;
`endif

    assign w_idx   = ALUOutM[c_AW+1:2];
    assign w_full  = (r_count == c_CW'(SB_DEPTH));
    assign w_empty = (r_count == '0);

    // The head commits on the edge where its drain counter reaches the end.
    assign w_pop   = !w_empty && (r_drainCnt == c_DW'(DRAIN_LAT - 1));

    // A full buffer can still accept a store when the head leaves on the same edge.
    assign w_push  = MemWriteM && (!w_full || w_pop);
    assign w_drop  = MemWriteM && w_full && !w_pop;

    // Walk entries oldest to youngest so the last match wins (youngest).
    // Validity is by age relative to head, so pointer equality never matters.
    always_comb begin
        w_hit     = 1'b0;
`ifdef DMEM_SB_FORWARD_EN
        w_fwdData = '0;
`endif
        for (int i = 0; i < SB_DEPTH; i++) begin
            if ((c_CW'(i) < r_count) && (r_sbIdx[r_head + c_PW'(i)] == w_idx)) begin
                w_hit     = 1'b1;
`ifdef DMEM_SB_FORWARD_EN
                w_fwdData = r_sbData[r_head + c_PW'(i)];
`endif
            end
        end
    end

`ifdef DMEM_SB_FORWARD_EN
    assign DmmRD   = w_hit ? w_fwdData : r_mem[w_idx];
    assign StallSB = w_full && !w_pop;
`else
    assign DmmRD   = r_mem[w_idx];
    assign StallSB = (w_full && !w_pop) || (MemtoRegM && w_hit);
`endif

    // Address bits outside the word index wrap by design and are not decoded.
`ifdef DMEM_SB_FORWARD_EN
    logic w_unusedBits;
    assign w_unusedBits = ^{MemtoRegM, ALUOutM[31:c_AW+2], ALUOutM[1:0]};
`else
    logic w_unusedBits;
    assign w_unusedBits = ^{ALUOutM[31:c_AW+2], ALUOutM[1:0]};
`endif

    assign SbCount    = r_count;
    assign SbEmpty    = w_empty;
    assign SbOverflow = r_overflow;

    // Control state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_drainCnt <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + c_PW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + c_PW'(1);
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase

            // Held at zero while empty so a fresh head always starts a full drain.
            if (w_pop || w_empty) begin
                r_drainCnt <= '0;
            end else begin
                r_drainCnt <= r_drainCnt + c_DW'(1);
            end

            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Entry payload; validity is carried entirely by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_sbIdx[r_tail]  <= w_idx;
            r_sbData[r_tail] <= WriteDataM;
        end
    end

    // Array contents survive reset; a commit scheduled on a reset edge is discarded.
    always_ff @(posedge clk) begin
        if (!reset && w_pop) begin
            r_mem[r_sbIdx[r_head]] <= r_sbData[r_head];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_store_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_store_buffer
//  Purpose  : Self-checking bench for dmem_store_buffer. A vector table covers
//             the basic store/load path, directed sequences cover overflow,
//             same-address ordering, reset and pointer wrap, and a random run
//             is checked against a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dmem_store_buffer;

    localparam int MEM_WORDS = 256;
    localparam int SB_DEPTH  = 4;
    localparam int DRAIN_LAT = 2;
`ifdef DMEM_SB_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWriteM;
    logic        MemtoRegM;
    logic [31:0] ALUOutM;
    logic [31:0] WriteDataM;
    logic [31:0] DmmRD;
    logic        StallSB;
    logic [2:0]  SbCount;
    logic        SbEmpty;
    logic        SbOverflow;

    always #5 clk = ~clk;

    dmem_store_buffer #(
        .MEM_WORDS (MEM_WORDS),
        .SB_DEPTH  (SB_DEPTH),
        .DRAIN_LAT (DRAIN_LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .MemWriteM  (MemWriteM),
        .MemtoRegM  (MemtoRegM),
        .ALUOutM    (ALUOutM),
        .WriteDataM (WriteDataM),
        .DmmRD      (DmmRD),
        .StallSB    (StallSB),
        .SbCount    (SbCount),
        .SbEmpty    (SbEmpty),
        .SbOverflow (SbOverflow)
    );

    int    nChecks = 0;
    int    nPass   = 0;
    string phase   = "init";

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s.%s: got %h, expected %h", phase, name, act, exp);
    endtask

    // ---------------- reference model: FIFO of pending stores + word array
    typedef struct packed {
        int          idx;
        logic [31:0] data;
    } sbEnt_t;

    sbEnt_t      mq[$];
    logic [31:0] mMem   [MEM_WORDS];
    bit          mKnown [MEM_WORDS];
    int          mAge;     // cycles the current head has spent draining
    bit          mOvf;

    function automatic int wordIdx(input logic [31:0] a);
        return int'(a[9:2]);
    endfunction

    task automatic applyIn(input bit rst, input bit we, input bit re,
                           input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        reset      = rst;
        MemWriteM  = we;
        MemtoRegM  = re;
        ALUOutM    = addr;
        WriteDataM = wd;
        #1;
    endtask

    task automatic modelCheck();
        int          idx;
        bit          pop;
        bit          full;
        bit          hit;
        logic [31:0] hd;
        idx  = wordIdx(ALUOutM);
        pop  = (mq.size() > 0) && (mAge == DRAIN_LAT - 1);
        full = (mq.size() == SB_DEPTH);
        hit  = 1'b0;
        hd   = '0;
        foreach (mq[i]) begin
            if (mq[i].idx == idx) begin
                hit = 1'b1;
                hd  = mq[i].data;
            end
        end
        check("count", 32'(SbCount), 32'(mq.size()));
        check("empty", 32'(SbEmpty), 32'(mq.size() == 0));
        check("stall", 32'(StallSB), 32'((full && !pop) || (!FWD && MemtoRegM && hit)));
        check("ovf",   32'(SbOverflow), 32'(mOvf));
        if (!(MemWriteM && MemtoRegM)) begin
            if (FWD && hit)       check("rd", DmmRD, hd);
            else if (mKnown[idx]) check("rd", DmmRD, mMem[idx]);
        end
    endtask

    task automatic advance();
        bit pop;
        bit full;
        int idx;
        pop  = (mq.size() > 0) && (mAge == DRAIN_LAT - 1);
        full = (mq.size() == SB_DEPTH);
        idx  = wordIdx(ALUOutM);
        @(posedge clk);
        if (reset) begin
            mq.delete();
            mAge = 0;
            mOvf = 1'b0;
        end else begin
            if (pop) begin
                mMem[mq[0].idx]   = mq[0].data;
                mKnown[mq[0].idx] = 1'b1;
                void'(mq.pop_front());
                mAge = 0;
            end else if (mq.size() > 0) begin
                mAge++;
            end
            if (MemWriteM) begin
                if (!full || pop) mq.push_back('{idx: idx, data: WriteDataM});
                else              mOvf = 1'b1;
            end
        end
    endtask

    task automatic step(input bit rst, input bit we, input bit re,
                        input logic [31:0] addr, input logic [31:0] wd);
        applyIn(rst, we, re, addr, wd);
        modelCheck();
        advance();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // ---------------- vector table
    typedef struct {
        bit          we;
        bit          re;
        logic [31:0] addr;
        logic [31:0] wd;
        int          expCount;
        bit          expStall;
        bit          chkRd;
        logic [31:0] expRd;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) mKnown[i] = 1'b0;
        mAge = 0;
        mOvf = 1'b0;

        // store, idle, read back, then store followed immediately by a load
        tbl[0] = '{1, 0, 32'h10, 32'hDEADBEEF, 0, 0,    0,   32'h0};
        tbl[1] = '{0, 0, 32'h00, 32'h0,        1, 0,    0,   32'h0};
        tbl[2] = '{0, 0, 32'h00, 32'h0,        1, 0,    0,   32'h0};
        tbl[3] = '{0, 1, 32'h10, 32'h0,        0, 0,    1,   32'hDEADBEEF};
        tbl[4] = '{1, 0, 32'h20, 32'h11111111, 0, 0,    0,   32'h0};
        tbl[5] = '{0, 1, 32'h20, 32'h0,        1, !FWD, FWD, 32'h11111111};
        tbl[6] = '{0, 1, 32'h20, 32'h0,        1, !FWD, FWD, 32'h11111111};
        tbl[7] = '{0, 1, 32'h20, 32'h0,        0, 0,    1,   32'h11111111};

        // reset (initial state is not modelled, so only the post-reset state is checked)
        phase = "reset";
        applyIn(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        advance();
        applyIn(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("count", 32'(SbCount), 32'd0);
        check("empty", 32'(SbEmpty), 32'd1);
        check("ovf",   32'(SbOverflow), 32'd0);
        check("stall", 32'(StallSB), 32'd0);
        advance();

        phase = "table";
        for (int v = 0; v < 8; v++) begin
            applyIn(1'b0, tbl[v].we, tbl[v].re, tbl[v].addr, tbl[v].wd);
            check($sformatf("v%0d.count", v), 32'(SbCount), 32'(tbl[v].expCount));
            check($sformatf("v%0d.stall", v), 32'(StallSB), 32'(tbl[v].expStall));
            if (tbl[v].chkRd) check($sformatf("v%0d.rd", v), DmmRD, tbl[v].expRd);
            modelCheck();
            advance();
        end

        // two stores to one word, load before commit sees the younger one
        phase = "youngest";
        step(1'b0, 1'b1, 1'b0, 32'h30, 32'h0000000A);
        step(1'b0, 1'b1, 1'b0, 32'h30, 32'h0000000B);
        applyIn(1'b0, 1'b0, 1'b1, 32'h30, 32'h0);
        check("ldStall", 32'(StallSB), 32'(!FWD));
        modelCheck();
        advance();
        idle(4);
        applyIn(1'b0, 1'b0, 1'b1, 32'h30, 32'h0);
        check("afterDrain", DmmRD, 32'h0000000B);
        modelCheck();
        advance();

        // back-to-back stores with the stall ignored: the 8th lands when full with no pop
        phase = "overflow";
        for (int k = 0; k < 8; k++) begin
            logic [31:0] a;
            logic [31:0] d;
            a = 32'h100 + 32'(k * 4);
            d = 32'hA0000000 + 32'(k);
            if (k == 7) begin
                a = 32'h100;
                d = 32'hBAD0BAD0;
            end
            applyIn(1'b0, 1'b1, 1'b0, a, d);
            if (k == 6) begin
                check("fullPopCount", 32'(SbCount), 32'd4);
                check("fullPopStall", 32'(StallSB), 32'd0);
            end
            if (k == 7) begin
                check("fullStall", 32'(StallSB), 32'd1);
                check("preDropOvf", 32'(SbOverflow), 32'd0);
            end
            modelCheck();
            advance();
        end
        applyIn(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("postDropOvf", 32'(SbOverflow), 32'd1);
        modelCheck();
        advance();
        idle(10);
        for (int k = 0; k < 7; k++) begin
            applyIn(1'b0, 1'b0, 1'b1, 32'h100 + 32'(k * 4), 32'h0);
            check($sformatf("inOrder%0d", k), DmmRD, 32'hA0000000 + 32'(k));
            modelCheck();
            advance();
        end

        // reset with three entries pending (head mid-drain) discards them
        phase = "resetPending";
        step(1'b0, 1'b1, 1'b0, 32'h40, 32'h40404040);
        step(1'b0, 1'b1, 1'b0, 32'h10, 32'hEEEEEEE0);
        step(1'b0, 1'b1, 1'b0, 32'h20, 32'hEEEEEEE1);
        step(1'b0, 1'b1, 1'b0, 32'h30, 32'hEEEEEEE2);
        applyIn(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        check("preResetCount", 32'(SbCount), 32'd3);
        advance();
        applyIn(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("count", 32'(SbCount), 32'd0);
        check("empty", 32'(SbEmpty), 32'd1);
        check("ovf",   32'(SbOverflow), 32'd0);
        advance();
        idle(4);
        applyIn(1'b0, 1'b0, 1'b1, 32'h10, 32'h0);
        check("keep10", DmmRD, 32'hDEADBEEF);
        advance();
        applyIn(1'b0, 1'b0, 1'b1, 32'h20, 32'h0);
        check("keep20", DmmRD, 32'h11111111);
        advance();
        applyIn(1'b0, 1'b0, 1'b1, 32'h30, 32'h0);
        check("keep30", DmmRD, 32'h0000000B);
        advance();

        // ten spaced stores wrap the pointers twice
        phase = "wrap";
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b1, 1'b0, 32'h190 + 32'(k * 4), 32'h70000000 + 32'(k));
            idle(2);
        end
        idle(3);
        for (int k = 0; k < 10; k++) begin
            applyIn(1'b0, 1'b0, 1'b1, 32'h190 + 32'(k * 4), 32'h0);
            check($sformatf("word%0d", k), DmmRD, 32'h70000000 + 32'(k));
            modelCheck();
            advance();
        end

        // random traffic against the model; upper address bits exercise index wrap
        phase = "random";
        for (int n = 0; n < 600; n++) begin
            int          r;
            bit          we;
            bit          re;
            logic [31:0] a;
            r  = int'($urandom_range(0, 9));
            we = (r < 4);
            re = (r >= 4) && (r < 8);
            a  = {$urandom_range(0, 32'h003FFFFF) & 32'h003FFFFF, 10'h0}
               | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            step(1'b0, we, re, a, $urandom);
        end
        idle(12);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
`default_nettype wire
